// File: rtl/pe_ctx_seq.sv
// Context sequencer for a PE: replays a programmed list of control words
// (contexts 0..last_ctx) for a number of iterations, issuing NOP when idle or stalled.
module pe_ctx_seq #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [58:0]   cfg_data,
  input  logic          start,
  input  logic [AW-1:0] last_ctx,
  input  logic [7:0]    iter,
  input  logic          stall,
  output logic [8:0]    control_in,
  output logic [8:0]    control_out,
  output logic [5:0]    control_reg_1,
  output logic [5:0]    control_reg_2,
  output logic [5:0]    control_put_in,
  output logic [5:0]    control_put_out,
  output logic [5:0]    control_send,
  output logic [3:0]    control_pe2fu_1,
  output logic [3:0]    control_pe2fu_2,
  output logic          write_back,
  output logic          ld,
  output logic          ld_write,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ctx_ptr,
  output logic [7:0]    iter_cnt
);

  typedef struct packed {
    logic [8:0] control_in;
    logic [8:0] control_out;
    logic [5:0] control_reg_1;
    logic [5:0] control_reg_2;
    logic [5:0] control_put_in;
    logic [5:0] control_put_out;
    logic [5:0] control_send;
    logic [3:0] control_pe2fu_1;
    logic [3:0] control_pe2fu_2;
    logic       write_back;
    logic       ld;
    logic       ld_write;
  } ctx_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Only ld set: the register file sees a load with no write-back, i.e. a bubble.
  localparam ctx_word_t NOP_WORD = 59'd2;

  logic [58:0] mem [DEPTH];

  state_t          state;
  ctx_word_t       word_q;
  logic            done_q;
  logic [AW-1:0]   ptr_q;
  logic [7:0]      iter_cnt_q;
  logic [AW-1:0]   last_q;
  logic [7:0]      iter_max_q;

  // NOTE: the context memory has no reset; it is plain storage and survives RST,
  // so a restart after an abort replays the same program.
  always_ff @(posedge CLK) begin
    if (!RST && cfg_we && state == IDLE) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values, e.g. the RUN branch reads ptr_q before it advances.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      word_q     <= NOP_WORD;
      done_q     <= 1'b0;
      ptr_q      <= '0;
      iter_cnt_q <= '0;
      last_q     <= '0;
      iter_max_q <= 8'd1;
    end else begin
      word_q <= NOP_WORD;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            ptr_q      <= '0;
            iter_cnt_q <= '0;
            last_q     <= last_ctx;
            iter_max_q <= (iter == 8'd0) ? 8'd1 : iter;
          end
        end
        RUN: begin
          if (!stall) begin
            word_q <= mem[ptr_q];
            if (ptr_q != last_q) begin
              ptr_q <= ptr_q + 1'b1;
            end else if ({1'b0, iter_cnt_q} + 9'd1 >= {1'b0, iter_max_q}) begin
              state <= DONE;
            end else begin
              ptr_q      <= '0;
              iter_cnt_q <= iter_cnt_q + 8'd1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign control_in      = word_q.control_in;
  assign control_out     = word_q.control_out;
  assign control_reg_1   = word_q.control_reg_1;
  assign control_reg_2   = word_q.control_reg_2;
  assign control_put_in  = word_q.control_put_in;
  assign control_put_out = word_q.control_put_out;
  assign control_send    = word_q.control_send;
  assign control_pe2fu_1 = word_q.control_pe2fu_1;
  assign control_pe2fu_2 = word_q.control_pe2fu_2;
  assign write_back      = word_q.write_back;
  assign ld              = word_q.ld;
  assign ld_write        = word_q.ld_write;

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign ctx_ptr  = ptr_q;
  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Randomized bench for pe_ctx_seq: a transaction-level model expands each start
// into a queue of (context, iteration) issues and predicts every output each cycle.
module tb_pe_ctx_seq;

  localparam logic [58:0] NOP_W = 59'd2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [58:0] cfg_data = '0;
  logic        start = 1'b0;
  logic [3:0]  last_ctx = '0;
  logic [7:0]  iter = '0;
  logic        stall = 1'b0;

  logic [8:0] control_in, control_out;
  logic [5:0] control_reg_1, control_reg_2, control_put_in, control_put_out, control_send;
  logic [3:0] control_pe2fu_1, control_pe2fu_2;
  logic       write_back, ld, ld_write, busy, done;
  logic [3:0] ctx_ptr;
  logic [7:0] iter_cnt;

  pe_ctx_seq #(.DEPTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .last_ctx(last_ctx), .iter(iter), .stall(stall),
    .control_in(control_in), .control_out(control_out),
    .control_reg_1(control_reg_1), .control_reg_2(control_reg_2),
    .control_put_in(control_put_in), .control_put_out(control_put_out),
    .control_send(control_send),
    .control_pe2fu_1(control_pe2fu_1), .control_pe2fu_2(control_pe2fu_2),
    .write_back(write_back), .ld(ld), .ld_write(ld_write),
    .busy(busy), .done(done), .ctx_ptr(ctx_ptr), .iter_cnt(iter_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: memory image plus the list of issues still owed.
  typedef struct {
    int idx;
    int it;
  } issue_t;

  logic [58:0] mem_m [16];
  issue_t      pend[$];
  bit          m_run = 1'b0;
  bit          m_drain = 1'b0;
  logic [58:0] m_word = NOP_W;
  bit          m_done = 1'b0;
  int          m_ptr = 0;
  int          m_iter = 0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [58:0] mk(input int put_in);
    logic [58:0] w;
    w = '0;
    w[28:23] = 6'(put_in);
    return w;
  endfunction

  function automatic logic [58:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[58:0];
  endfunction

  task automatic model_edge();
    issue_t e;
    int n_it;
    if (RST) begin
      m_run = 0; m_drain = 0; m_word = NOP_W; m_done = 0; m_ptr = 0; m_iter = 0;
      pend.delete();
    end else begin
      m_word = NOP_W;
      m_done = 0;
      if (m_drain) begin
        m_done = 1;
        m_drain = 0;
      end else if (m_run) begin
        if (!stall) begin
          e = pend.pop_front();
          m_word = mem_m[e.idx];
          if (pend.size() == 0) begin
            m_run = 0; m_drain = 1; m_ptr = e.idx; m_iter = e.it;
          end else begin
            m_ptr = pend[0].idx; m_iter = pend[0].it;
          end
        end
      end else begin
        if (cfg_we) mem_m[cfg_addr] = cfg_data;
        if (start) begin
          n_it = (iter == 0) ? 1 : int'(iter);
          for (int i = 0; i < n_it; i++)
            for (int c = 0; c <= int'(last_ctx); c++) begin
              e.idx = c; e.it = i;
              pend.push_back(e);
            end
          m_run = 1; m_ptr = 0; m_iter = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    check("word", 64'({control_in, control_out, control_reg_1, control_reg_2,
                       control_put_in, control_put_out, control_send,
                       control_pe2fu_1, control_pe2fu_2, write_back, ld, ld_write}),
          64'(m_word));
    check("busy", 64'(busy), 64'(m_run || m_drain));
    check("done", 64'(done), 64'(m_done));
    check("ctx_ptr", 64'(ctx_ptr), 64'(m_ptr));
    check("iter_cnt", 64'(iter_cnt), 64'(m_iter));
  endtask

  task automatic idle(input int n);
    RST = 0; cfg_we = 0; start = 0; stall = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cfg_write(input int a, input logic [58:0] d);
    cfg_we = 1; cfg_addr = 4'(a); cfg_data = d;
    cycle();
    cfg_we = 0;
  endtask

  task automatic run(input int last, input int it, input int stall_pct,
                     input logic [31:0] stall_mask, input int abort_at, input bit noise,
                     input bit wr0, input logic [58:0] wr0_data, input int noise_addr_max);
    int k;
    k = 0;
    start = 1; last_ctx = 4'(last); iter = 8'(it);
    cfg_we = wr0; cfg_addr = '0; cfg_data = wr0_data;
    cycle();
    start = 0; cfg_we = 0;
    while ((m_run || m_drain) && k < 500) begin
      stall = (k < 32 && stall_mask[k]) || (int'($urandom_range(99)) < stall_pct);
      RST = (k == abort_at);
      if (noise) begin
        cfg_we = 1'($urandom_range(1));
        start = 1'($urandom_range(1));
        cfg_addr = 4'($urandom_range(noise_addr_max));
        cfg_data = rnd_word();
        last_ctx = 4'($urandom_range(15));
        iter = 8'($urandom_range(255));
      end
      cycle();
      k++;
    end
    RST = 0; stall = 0; cfg_we = 0; start = 0;
    if (m_run || m_drain) check("timeout", 64'd1, 64'd0);
  endtask

  initial begin
    RST = 1;
    cycle();
    cycle();
    RST = 0;
    idle(1);

    // Three-context program, single pass, then three passes.
    for (int i = 0; i < 3; i++) cfg_write(i, mk(i + 1));
    run(2, 1, 0, 32'd0, -1, 0, 0, '0, 0);
    idle(2);
    run(2, 3, 0, 32'd0, -1, 0, 0, '0, 0);
    idle(2);

    // Two stall cycles while ctx_ptr is 1.
    run(2, 1, 0, 32'b110, -1, 0, 0, '0, 0);
    idle(1);

    // Abort during the second iteration, then replay.
    run(2, 3, 0, 32'd0, 4, 0, 0, '0, 0);
    idle(2);
    run(2, 1, 0, 32'd0, -1, 0, 0, '0, 0);
    idle(1);

    // Writes and starts while busy are ignored; iter=0 with last_ctx=0.
    run(2, 2, 0, 32'd0, -1, 1, 0, '0, 2);
    idle(1);
    run(2, 1, 0, 32'd0, -1, 0, 0, '0, 0);
    idle(1);
    run(0, 0, 0, 32'd0, -1, 0, 0, '0, 0);
    idle(1);

    // Config write on the start edge is seen by the first read.
    run(1, 1, 0, 32'd0, -1, 0, 1, mk(9), 0);
    idle(1);

    // Randomized programs, stalls, busy-time noise and occasional aborts.
    for (int i = 0; i < 16; i++) cfg_write(i, rnd_word());
    for (int r = 0; r < 24; r++) begin
      run(int'($urandom_range(15)), int'($urandom_range(4)), 25, 32'd0,
          ($urandom_range(7) == 0) ? int'($urandom_range(20)) : -1,
          1'($urandom_range(1)), 1'($urandom_range(1)), rnd_word(), 15);
      idle(int'($urandom_range(2)));
      if ($urandom_range(3) == 0) cfg_write(int'($urandom_range(15)), rnd_word());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_ctx_seq.md
PE_CTX_SEQ -- requirements
Module: pe_ctx_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of context words; AW = log2(DEPTH) = 4.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cfg_we  input  1 / cfg_addr  input  AW / cfg_data  input  59: context-memory write.
REQ-005 SHALL have ports start  input  1 / last_ctx  input  AW / iter  input  8: launch, last context index, iteration count.
REQ-006 SHALL have port stall  input  1  holds sequencing, issues NOP.
REQ-007 SHALL have outputs control_in 9, control_out 9, control_reg_1 6, control_reg_2 6, control_put_in 6, control_put_out 6, control_send 6, control_pe2fu_1 4, control_pe2fu_2 4, write_back 1, ld 1, ld_write 1, all registered, driving the PE register file.
REQ-008 SHALL have outputs busy 1 (state != IDLE), done 1 (one-cycle pulse), ctx_ptr AW, iter_cnt 8.

Function
REQ-009 Context word packing, MSB first: control_in[58:50], control_out[49:41], control_reg_1[40:35], control_reg_2[34:29], control_put_in[28:23], control_put_out[22:17], control_send[16:11], control_pe2fu_1[10:7], control_pe2fu_2[6:3], write_back[2], ld[1], ld_write[0].
REQ-010 NOP word: all fields 0 except ld=1 (write_back=0, ld_write=0, so no register-file write).
REQ-011 Context memory DEPTH x 59, written at edge when cfg_we=1 and state IDLE; cfg_we ignored otherwise; memory not reset.
REQ-012 States IDLE, RUN, DONE.
REQ-013 IDLE: outputs NOP; start=1 -> RUN, ptr<=0, iter_cnt<=0; last_ctx and iter latched at the same edge.
REQ-014 RUN, stall=0: outputs <= mem[ptr]; then if ptr != last_ctx, ptr<=ptr+1; else if iter_cnt+1 >= max(iter,1) -> DONE; else ptr<=0, iter_cnt<=iter_cnt+1.
REQ-015 RUN, stall=1: outputs <= NOP; ptr and iter_cnt held; the held context issues on the first non-stall cycle.
REQ-016 DONE: outputs <= NOP, done <= 1 for exactly one cycle, -> IDLE.
REQ-017 Latency: start sampled at edge e0, context 0 visible after e1, context k after e(k+1) absent stalls.
REQ-018 cfg write at e0 together with accepted start: data is visible to the e1 read.
REQ-019 start while busy is ignored; iter=0 treated as 1; last_ctx=0 runs a single context per iteration.
REQ-020 ptr wraps only via REQ-014; last_ctx >= DEPTH impossible by width.
REQ-021 Total issued non-NOP cycles = (last_ctx+1) x max(iter,1).

Reset
REQ-022 RST=1 at an edge: state IDLE, all control outputs NOP, done=0, busy=0, ctx_ptr=0, iter_cnt=0; overrides start, stall, cfg_we.
REQ-023 RST mid-RUN aborts immediately; next cycle outputs NOP; memory contents retained; a new start replays from context 0.

Verification
REQ-024 Load mem[0..2] with control_put_in = 1, 2, 3 (ld=0); start, last_ctx=2, iter=1 -> put_in 1, 2, 3 on consecutive cycles starting 2 edges after start, then NOP with done=1, busy falls next cycle.
REQ-025 Same program, iter=3 -> sequence 1, 2, 3 repeated 3 times (9 cycles), iter_cnt 0->1->2, single done pulse.
REQ-026 stall=1 for 2 cycles while ctx_ptr=1 -> 2 NOP cycles, then context 1 issued, no context skipped or duplicated.
REQ-027 RST pulsed during iteration 2 -> NOP next cycle, busy=0, no done; restart replays from context 0 with unchanged memory.
REQ-028 cfg_we=1 and start=1 while busy -> memory unchanged and run unaffected; iter=0, last_ctx=0 -> exactly one context, then done.
